// File: rtl/mod_360.sv
// mod_360 -- registered modulo-360 reducer for 11-bit unsigned operands.
//
// Maps a raw 11-bit position sum (0..2047) to a hue index 0..359.
// The block has a single pipeline register stage with a valid flag.
// There is no combinational path from any input to any output.
//
// Optional feature: define MOD_360_QUOT_EN to add the `quot` output (din div 360, 0..5).
// `quot` is registered alongside `rem` under the same valid and reset rules.
// `rem`/`out_valid` behave identically in both builds.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   din qualifies this cycle
//   din        in  11   unsigned operand
//   out_valid  out  1   rem/quot updated from an accepted operand (copy of in_valid, delayed 1)
//   rem        out  9   din mod 360
//   quot       out  3   din div 360 (only with MOD_360_QUOT_EN)

module mod_360 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [10:0] din,
   output logic        out_valid,
`ifdef MOD_360_QUOT_EN
   output logic [8:0]  rem,
   output logic [2:0]  quot
`else
   output logic [8:0]  rem
`endif
);

   logic [4:0]  w_ge;        // din >= 360*k for k = 1..5
   logic [2:0]  w_q;         // number of thresholds reached
   logic [10:0] w_sub;       // 360 * w_q
   logic [10:0] w_diff;      // din - 360*q, always < 360
   logic [8:0]  w_rem;
   logic [1:0]  w_unused_diff;

   logic        r_out_valid;
   logic [8:0]  r_rem;

   assign w_ge[0] = (din >= 11'd360);
   assign w_ge[1] = (din >= 11'd720);
   assign w_ge[2] = (din >= 11'd1080);
   assign w_ge[3] = (din >= 11'd1440);
   assign w_ge[4] = (din >= 11'd1800);

   // Thresholds are monotonic, so w_ge is a thermometer code and the count is direct.
   always_comb begin
      w_q   = 3'd0;
      w_sub = 11'd0;
      unique casez (w_ge)
         5'b00000: begin w_q = 3'd0; w_sub = 11'd0;    end
         5'b00001: begin w_q = 3'd1; w_sub = 11'd360;  end
         5'b00011: begin w_q = 3'd2; w_sub = 11'd720;  end
         5'b00111: begin w_q = 3'd3; w_sub = 11'd1080; end
         5'b01111: begin w_q = 3'd4; w_sub = 11'd1440; end
         5'b11111: begin w_q = 3'd5; w_sub = 11'd1800; end
         default:  begin w_q = 3'd0; w_sub = 11'd0;    end
      endcase
   end

   assign w_diff = din - w_sub;
   // Remainder is < 360, so the upper two bits are always zero.
   assign w_rem         = w_diff[8:0];
   assign w_unused_diff = w_diff[10:9];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_rem       <= 9'd0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_rem <= w_rem;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign rem       = r_rem;

`ifdef MOD_360_QUOT_EN
   logic [2:0] r_quot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quot <= 3'd0;
      end else if (in_valid) begin
         r_quot <= w_q;
      end
   end

   assign quot = r_quot;
`else
   logic [2:0] w_unused_q;
   assign w_unused_q = w_q;
`endif

endmodule

// File: tb/tb_mod_360.sv
module tb_mod_360;

   typedef struct packed {
      logic [8:0] rem;
      logic [2:0] quot;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [10:0] din;
   logic        out_valid;
   logic [8:0]  rem;
   logic [2:0]  quot_s;

   exp_t        sb_q[$];
   logic        exp_valid;
   logic [8:0]  held_rem;
   logic [2:0]  held_quot;
   int          n_tests;
   int          n_fail;

`ifdef MOD_360_QUOT_EN
   logic [2:0] quot;
   assign quot_s = quot;
   mod_360 u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din       (din),
      .out_valid (out_valid),
      .rem       (rem),
      .quot      (quot)
   );
`else
   assign quot_s = 3'd0;
   mod_360 u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din       (din),
      .out_valid (out_valid),
      .rem       (rem)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_out_valid", int'(out_valid), 0);
         check("reset_rem", int'(rem), 0);
`ifdef MOD_360_QUOT_EN
         check("reset_quot", int'(quot_s), 0);
`endif
      end else begin
         check("out_valid", int'(out_valid), int'(exp_valid));
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               held_rem  = e.rem;
               held_quot = e.quot;
               check("rem", int'(rem), int'(e.rem));
               check("rem_range", int'(rem < 9'd360), 1);
`ifdef MOD_360_QUOT_EN
               check("quot", int'(quot_s), int'(e.quot));
               check("quot_x360_plus_rem", int'(quot_s) * 360 + int'(rem),
                     int'(e.quot) * 360 + int'(e.rem));
`endif
            end
         end else begin
            check("hold_rem", int'(rem), int'(held_rem));
`ifdef MOD_360_QUOT_EN
            check("hold_quot", int'(quot_s), int'(held_quot));
`endif
         end
      end
   end

   // Drive one cycle; inputs change 1 time unit after the rising edge.
   task automatic send(input logic v, input int d, input int er, input int eq);
      exp_t e;
      in_valid = v;
      din      = 11'(d);
      @(posedge clk);
      exp_valid = v;
      if (v) begin
         e.rem  = 9'(er);
         e.quot = 3'(eq);
         sb_q.push_back(e);
      end
      #1;
   endtask

   task automatic enter_reset();
      rst_n     = 1'b0;
      sb_q.delete();
      exp_valid = 1'b0;
      held_rem  = 9'd0;
      held_quot = 3'd0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      in_valid  = 1'b1;
      din       = 11'd1000;
      exp_valid = 1'b0;
      held_rem  = 9'd0;
      held_quot = 3'd0;
      rst_n     = 1'b1;
      #2;
      enter_reset();
      // Held in reset with a valid operand present: outputs stay zero.
      repeat (4) @(posedge clk);
      #1;
      check("reset_hold_rem", int'(rem), 0);
      release_reset();
      send(1'b1, 1000, 280, 2);
      send(1'b0, 0, 0, 0);

      // Threshold boundaries, back-to-back.
      send(1'b1, 0,    0,   0);
      send(1'b1, 359,  359, 0);
      send(1'b1, 360,  0,   1);
      send(1'b1, 719,  359, 1);
      send(1'b1, 720,  0,   2);
      send(1'b1, 1079, 359, 2);
      send(1'b1, 1080, 0,   3);
      send(1'b1, 1440, 0,   4);
      send(1'b1, 1799, 359, 4);
      send(1'b1, 1800, 0,   5);
      send(1'b1, 2047, 247, 5);

      // Hold: result stays while in_valid is low and din toggles.
      send(1'b1, 500,  140, 1);
      send(1'b0, 2047, 0,   0);
      send(1'b0, 0,    0,   0);
      send(1'b0, 1234, 0,   0);
      send(1'b0, 0,    0,   0);

      // Exhaustive sweep.
      for (int d = 0; d < 2048; d++) begin
         send(1'b1, d, d % 360, d / 360);
      end
      send(1'b0, 0, 0, 0);

      // Mid-stream reset discards the 700 result.
      send(1'b1, 700, 340, 1);
      enter_reset();
      in_valid = 1'b0;
      #1;
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_rem", int'(rem), 0);
`ifdef MOD_360_QUOT_EN
      check("midreset_quot", int'(quot_s), 0);
`endif
      release_reset();
      send(1'b1, 1500, 60, 4);
      send(1'b0, 0, 0, 0);
      send(1'b0, 0, 0, 0);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
